// File: rtl/quant_pkg.sv
// Shared constants and the accumulator saturation helper for the 1x8 dequantizer.
package quant_pkg;

  localparam int LANES   = 8;
  localparam int Q_W     = 4;
  localparam int ACC_W   = 15;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 4;
  localparam int DIFF_W  = 5;
  localparam int PROD_W  = 21;
  localparam int RND_W   = 22;
  localparam int ACC_MAX = 16383;
  localparam int ACC_MIN = -16384;

  localparam logic signed [RND_W-1:0] RND_MAX = 22'sd16383;
  localparam logic signed [RND_W-1:0] RND_MIN = -22'sd16384;

  // Returns {sat_flag, acc}; the flag is set whenever the value had to be clamped.
  function automatic logic [ACC_W:0] sat_acc(input logic signed [RND_W-1:0] value);
    logic [ACC_W:0] res;
    if (value > RND_MAX) begin
      res = {1'b1, 15'h3FFF};
    end else if (value < RND_MIN) begin
      res = {1'b1, 15'h4000};
    end else begin
      res = {1'b0, value[ACC_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/module_dequant_lane.sv
// One dequantizer lane: stage 1 removes the zero point, stage 2 scales, rounds and saturates.
module module_dequant_lane
  import quant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s1_en,
  input  logic                      s2_en,
  input  logic [Q_W-1:0]            q,
  input  logic [Q_W-1:0]            zero_point,
  input  logic signed [SCALE_W-1:0] s1_scale,
  input  logic [SHIFT_W-1:0]        s1_shift,
  output logic [ACC_W-1:0]          acc,
  output logic                      sat
);

  logic signed [DIFF_W-1:0] diff_d, diff_q;
  logic [ACC_W-1:0]         acc_d, acc_q;
  logic                     sat_d, sat_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [RND_W-1:0]  wide, bias, rnd;
  logic [ACC_W:0]           sat_res;

  // Next-state datapath for both stages; the 22-bit width keeps the rounding add from overflowing.
  always_comb begin
    diff_d = diff_q;
    if (s1_en) begin
      diff_d = {1'b0, q} - {1'b0, zero_point};
    end else begin
      diff_d = diff_q;
    end

    prod = $signed({{(PROD_W-DIFF_W){diff_q[DIFF_W-1]}}, diff_q})
         * $signed({{(PROD_W-SCALE_W){s1_scale[SCALE_W-1]}}, s1_scale});
    wide = {prod[PROD_W-1], prod};
    if (s1_shift != 4'd0) begin
      bias = 22'sd1 <<< (s1_shift - 4'd1);
      rnd  = (wide + bias) >>> s1_shift;
    end else begin
      bias = '0;
      rnd  = wide;
    end
    sat_res = sat_acc(rnd);

    acc_d = acc_q;
    sat_d = sat_q;
    if (s2_en) begin
      {sat_d, acc_d} = sat_res;
    end else begin
      acc_d = acc_q;
      sat_d = sat_q;
    end
  end

  // Lane pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      diff_q <= diff_d;
      acc_q  <= acc_d;
      sat_q  <= sat_d;
    end
  end

  assign acc = acc_q;
  assign sat = sat_q;

endmodule

// File: rtl/module_dequant_1x8.sv
// Eight-lane 4-bit to 15-bit dequantizer: two-stage valid/ready pipeline with a sticky saturation counter.
module module_dequant_1x8
  import quant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic [Q_W-1:0]            zero_point,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*Q_W-1:0]      in_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_acc,
  output logic [LANES-1:0]          out_sat,
  input  logic                      sat_clear,
  output logic [15:0]               sat_count
);

  logic                      s1_valid_d, s1_valid_q;
  logic                      s2_valid_d, s2_valid_q;
  logic signed [SCALE_W-1:0] scale_d, scale_q;
  logic [SHIFT_W-1:0]        shift_d, shift_q;
  logic [15:0]               sat_count_d, sat_count_q;
  logic                      s2_ready, s1_en, s2_en, out_fire;

  // A stage may load when it is empty or its occupant leaves this cycle.
  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign s1_en    = in_valid && in_ready;
  assign s2_en    = s1_valid_q && s2_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Control next-state: occupancy, per-beat config capture and the saturation counter.
  always_comb begin
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s2_valid_d  = s2_ready ? s1_valid_q : s2_valid_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    sat_count_d = sat_count_q;
    if (s1_en) begin
      scale_d = scale;
      shift_d = shift;
    end else begin
      scale_d = scale_q;
      shift_d = shift_q;
    end
    if (sat_clear) begin
      sat_count_d = 16'h0000;
    end else if (out_fire && (|out_sat) && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      scale_q     <= '0;
      shift_q     <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      sat_count_q <= sat_count_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    module_dequant_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .s1_en      (s1_en),
      .s2_en      (s2_en),
      .q          (in_q[i*Q_W +: Q_W]),
      .zero_point (zero_point),
      .s1_scale   (scale_q),
      .s1_shift   (shift_q),
      .acc        (out_acc[i*ACC_W +: ACC_W]),
      .sat        (out_sat[i])
    );
  end

  assign out_valid = s2_valid_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_module_dequant_1x8.sv
// Directed bench for module_dequant_1x8: vector table plus backpressure, streaming and reset sequences.
module tb_module_dequant_1x8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] scale;
  logic [3:0]         shift, zero_point;
  logic               in_valid, in_ready;
  logic [31:0]        in_q;
  logic               out_valid, out_ready;
  logic [119:0]       out_acc;
  logic [7:0]         out_sat;
  logic               sat_clear;
  logic [15:0]        sat_count;

  module_dequant_1x8 dut (
    .clk(clk), .rst_n(rst_n), .scale(scale), .shift(shift), .zero_point(zero_point),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        q;
    logic [3:0]         zp;
    logic signed [15:0] sc;
    logic [3:0]         sh;
    logic [119:0]       acc;
    logic [7:0]         sat;
  } vec_t;

  vec_t         tv[10];
  int           n_vec = 0;
  int           n_miss = 0;
  int           cyc = 0;
  logic [119:0] mon_q[$];
  int           mon_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_q.push_back(out_acc);
      mon_t.push_back(cyc);
    end
  end

  function automatic logic [119:0] rep(input int v);
    logic [14:0] l;
    l = v[14:0];
    return {8{l}};
  endfunction

  function automatic logic [119:0] pk(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {15'(a7), 15'(a6), 15'(a5), 15'(a4), 15'(a3), 15'(a2), 15'(a1), 15'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i);
    in_q       = tv[i].q;
    zero_point = tv[i].zp;
    scale      = tv[i].sc;
    shift      = tv[i].sh;
  endtask

  // Single beat with empty pipeline; ends at the negedge where the result is visible.
  task automatic apply(input int i);
    step();
    set_in(i);
    in_valid = 1'b1;
    chk($sformatf("v%0d_in_ready", i), 120'(in_ready), 120'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_lat1", i), 120'(out_valid), 120'd0);
    step();
    @(negedge clk);
    chk($sformatf("v%0d_lat2", i), 120'(out_valid), 120'd1);
    chk($sformatf("v%0d_acc", i), out_acc, tv[i].acc);
    chk($sformatf("v%0d_sat", i), 120'(out_sat), 120'(tv[i].sat));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   k, sc_exp;
    int   idx[4];
    logic [3:0] nib;

    tv[0] = '{32'hAAAAAAAA, 4'd3,  16'sd100,   4'd2,  rep(175),    8'h00};
    tv[1] = '{32'h00000000, 4'd8,  16'sd300,   4'd0,  rep(-2400),  8'h00};
    tv[2] = '{32'h22222222, 4'd3,  16'sd3,     4'd1,  rep(-1),     8'h00};
    tv[3] = '{32'hFFFFFFFF, 4'd0,  16'sd32767, 4'd0,  rep(16383),  8'hFF};
    tv[4] = '{32'h00000000, 4'd15, 16'sd32767, 4'd0,  rep(-16384), 8'hFF};
    tv[5] = '{32'h76543210, 4'd4,  -16'sd5,    4'd1,  pk(10, 8, 5, 3, 0, -2, -5, -7), 8'h00};
    tv[6] = '{32'h7902E1F8, 4'd8,  16'sd2500,  4'd0,
              pk(0, 16383, -16384, 15000, -15000, -16384, 2500, -2500), 8'h26};
    tv[7] = '{32'hFFFFFFFF, 4'd0,  16'sh8000,  4'd15, rep(-15),    8'h00};
    tv[8] = '{32'h99999999, 4'd0,  16'sd8,     4'd4,  rep(5),      8'h00};
    tv[9] = '{32'h00000000, 4'd9,  16'sd8,     4'd4,  rep(-4),     8'h00};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
    in_q = '0; zero_point = '0; scale = '0; shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 120'(out_valid), 120'd0);
    chk("rst_out_acc", out_acc, 120'd0);
    chk("rst_out_sat", 120'(out_sat), 120'd0);
    chk("rst_sat_count", 120'(sat_count), 120'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 120'(in_ready), 120'd1);

    sc_exp = 0;
    for (int i = 0; i < 10; i++) begin
      apply(i);
      if (tv[i].sat != 8'h00) sc_exp++;
    end
    step();
    @(negedge clk);
    chk("sat_count_total", 120'(sat_count), 120'(sc_exp));

    step();
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    @(negedge clk);
    chk("sat_clear", 120'(sat_count), 120'd0);

    // sat_clear coinciding with a saturating output handshake must win.
    apply(4);
    step();
    @(negedge clk);
    chk("sat_count_one", 120'(sat_count), 120'd1);
    apply(3);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    @(negedge clk);
    chk("sat_clear_priority", 120'(sat_count), 120'd0);

    // Backpressure: only two beats fit, outputs hold while stalled.
    step();
    mon_q.delete(); mon_t.delete();
    out_ready = 1'b0; zero_point = 4'd0; scale = 16'sd1; shift = 4'd0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      nib = 4'(k + 1);
      in_q = {8{nib}};
      in_valid = 1'b1;
      @(negedge clk);
      if (c >= 2) begin
        chk($sformatf("bp_stall_valid_%0d", c), 120'(out_valid), 120'd1);
        chk($sformatf("bp_stall_acc_%0d", c), out_acc, rep(1));
      end
      if (in_ready) k++;
      step();
    end
    chk("bp_accepted", 120'(k), 120'd2);
    chk("bp_in_ready_low", 120'(in_ready), 120'd0);
    chk("bp_no_output", 120'(mon_q.size()), 120'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (mon_q.size() == 4) break;
      nib = 4'(k + 1);
      in_q = {8{nib}};
      in_valid = (k < 4);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_out_count", 120'(mon_q.size()), 120'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < mon_q.size()) chk($sformatf("bp_order_%0d", j), mon_q[j], rep(j + 1));
    end

    // Streaming with per-beat config.
    mon_q.delete(); mon_t.delete();
    idx[0] = 0; idx[1] = 5; idx[2] = 6; idx[3] = 8;
    for (int j = 0; j < 4; j++) begin
      set_in(idx[j]);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("st_in_ready_%0d", j), 120'(in_ready), 120'd1);
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mon_q.size() < 4) step();
    end
    chk("st_out_count", 120'(mon_q.size()), 120'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < mon_q.size()) begin
        chk($sformatf("st_acc_%0d", j), mon_q[j], tv[idx[j]].acc);
        chk($sformatf("st_rate_%0d", j), 120'(mon_t[j] - mon_t[0]), 120'(j));
      end
    end

    // Reset with two beats in flight.
    step();
    out_ready = 1'b0;
    set_in(3);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_pre_valid", 120'(out_valid), 120'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_now", 120'(out_valid), 120'd0);
    step();
    step();
    rst_n = 1'b1;
    mon_q.delete(); mon_t.delete();
    out_ready = 1'b1;
    repeat (5) step();
    chk("mr_no_stale", 120'(mon_q.size()), 120'd0);
    chk("mr_out_valid", 120'(out_valid), 120'd0);
    chk("mr_sat_count", 120'(sat_count), 120'd0);
    chk("mr_out_acc", out_acc, 120'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/module_dequant_1x8.md
Name: module_dequant_1x8

Overview:
- Eight-lane dequantizer: the inverse of the 1x8 requantizer. It turns packed 4-bit unsigned activations back into signed 15-bit accumulator-domain values.
- Per-lane arithmetic: out = sat15(round((q - zero_point) * scale >>> shift)).
- Sits between activation buffer reads and the next layer's accumulator/residual-add path.
- Two-stage pipeline with a valid/ready handshake on both sides, plus a sticky saturation counter for calibration debug.

Parameters:
- LANES, 8, number of parallel lanes.
- Q_W, 4, width of each quantized input lane.
- ACC_W, 15, width of each signed output lane.
- SCALE_W, 16, width of the signed scale.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- scale  in  16  signed multiplier; sampled with each accepted input beat
- shift  in  4  right-shift amount 0..15; sampled with each accepted beat
- zero_point  in  4  unsigned zero point; sampled with each accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_q  in  32  packed lanes; lane i = in_q[4i+3:4i], unsigned
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts this cycle
- out_acc  out  120  packed signed lanes; lane i = out_acc[15i+14:15i]
- out_sat  out  8  per-lane flag: this beat's lane saturated
- sat_clear  in  1  synchronous clear of sat_count
- sat_count  out  16  count of beats with any lane saturated; holds at 0xFFFF

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_acc=0, out_sat=0, sat_count=0. in_ready is 1 once reset is released.
- Reset mid-operation: all in-flight beats are discarded, none are emitted.
- Handshake:
  - A beat transfers when valid&&ready. Data is held stable while valid&&!ready.
  - A stage loads when it is empty or its contents leave in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Latency: input accept at cycle N gives out_valid at N+2 when there is no backpressure. Sustained throughput is 1 beat/clk.
- Capacity: two beats in flight. With out_ready=0, exactly 2 beats are accepted, then in_ready=0.
- Stage 1:
  - diff_i = {1'b0,q_i} - {1'b0,zero_point}, 5-bit signed, range -15..15.
  - Registered together with scale and shift, so config may change every beat.
- Stage 2:
  - prod = diff*scale, 21-bit signed.
  - If shift>0: r = (prod + (1<<(shift-1))) >>> shift (round half up), computed at 22 bits so the add cannot overflow.
  - If shift=0: r = prod.
  - Saturate to [-16384, 16383]; out_sat_i=1 when clamped.
  - out_acc and out_sat are registered and equal stage-2 contents.
- sat_count:
  - Increments by 1 on each output handshake where |out_sat != 0; saturates at 0xFFFF.
  - sat_clear has priority over an increment in the same cycle; the result is 0.
- out_acc/out_sat are don't-care when out_valid=0 but must not contain X after reset.

Decomposition:
- quant_pkg:
  - Constants Q_W, ACC_W, SCALE_W, PROD_W=21, ACC_MAX=16383, ACC_MIN=-16384.
  - Function sat_acc(value) returning {sat_flag, acc}.
- Sub-module module_dequant_lane: one lane's stage-1 subtract and stage-2 multiply/round/saturate datapath.
  - Datapath registers are enabled by the parent's stage-advance signals.
  - The parent owns the valid/ready control and the sat_count logic, and instantiates LANES lanes.

Test Plan:
- Basic: q=10, zp=3, scale=100, shift=2 -> out 175 (700+2>>>2), out_sat=0, out_valid exactly 2 clk after accept.
- Negative: q=0, zp=8, scale=300, shift=0 -> -2400. Negative rounding: q=2, zp=3, scale=3, shift=1 -> -1.
- Saturation:
  - q=15, zp=0, scale=32767, shift=0 -> 16383, out_sat lane=1.
  - q=0, zp=15, scale=32767 -> -16384.
  - sat_count increments once per beat; a sat_clear pulse -> 0.
- Backpressure:
  - Hold out_ready=0 and offer 4 beats with distinct lane values -> 2 accepted, in_ready=0.
  - Release out_ready -> all 4 beats emerge in order, no loss or duplication, outputs stable while stalled.
- Streaming with config changing every beat (different zp/scale/shift per beat) at out_ready=1 -> 1 beat/clk, each result uses its own beat's config.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately. After release no stale beat appears and sat_count=0.
